// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The controller FSM state is exported so checkers can observe it directly.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } pc_state_e;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bus between the pipeline (master: requests) and pipe_ctrl (slave: stall/flush outputs).
interface pipe_ctrl_if #(
   parameter int N_STAGE = 6,
   parameter int PC_W    = 32,
   parameter int LAT_W   = 6,
   parameter int CNT_W   = 16
);
   import pipe_ctrl_pkg::*;

   localparam int SW = idx_w(N_STAGE);

   logic [N_STAGE-1:0] stallreq;
   logic               lat_valid;
   logic [SW-1:0]      lat_stage;
   logic [LAT_W-1:0]   lat_cycles;
   logic               flush_req;
   logic [PC_W-1:0]    flush_pc;
   logic [N_STAGE-1:0] stall;
   logic               flush;
   logic [PC_W-1:0]    new_pc;
   logic               busy;
   logic [CNT_W-1:0]   stall_cnt;
   logic               timeout;
   pc_state_e          state;

   // lat_valid is accepted only in a cycle where busy=0, flush=0 and flush_req=0;
   // otherwise it is dropped, not queued (busy acts as the inverted ready).
   modport master (
      output stallreq, lat_valid, lat_stage, lat_cycles, flush_req, flush_pc,
      input  stall, flush, new_pc, busy, stall_cnt, timeout, state
   );

   modport slave (
      input  stallreq, lat_valid, lat_stage, lat_cycles, flush_req, flush_pc,
      output stall, flush, new_pc, busy, stall_cnt, timeout, state
   );

endinterface

// File: rtl/pipe_ctrl_stall_mask.sv
// Depth to thermometer encoder: bits [depth:0] set when en, all clear otherwise.
module pipe_ctrl_stall_mask
   import pipe_ctrl_pkg::*;
#(
   parameter int N_STAGE = 6,
   parameter int SW      = idx_w(N_STAGE)
) (
   input  logic               en,
   input  logic [SW-1:0]      depth,
   output logic [N_STAGE-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int k = 0; k < N_STAGE; k++) begin
         mask[k] = (en && (SW'(k) <= depth)) ? STOP : NO_STOP;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stall requests, fixed-latency holds and
// redirects into a thermometer stall vector, a flush pulse and a redirect PC.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int N_STAGE = 6,
   parameter int PC_W    = 32,
   parameter int LAT_W   = 6,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   localparam int SW   = idx_w(N_STAGE);
   localparam int WD_W = idx_w(TIMEOUT + 1);

   pc_state_e          state;
   logic [LAT_W-1:0]   lat_cnt;
   logic [SW-1:0]      hold_stage;
   logic [SW-1:0]      lat_stage_c;
   logic [SW-1:0]      depth;
   logic               any_req;
   logic               lat_take;
   logic [N_STAGE-1:0] stall_v;
   logic               flush_q;
   logic               busy_q;
   logic [PC_W-1:0]    new_pc_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [WD_W-1:0]    wd_cnt;
   logic               timeout_q;

   // Merge all stall sources into the deepest requested stage.
   always_comb begin
      lat_stage_c = (int'(bus.lat_stage) >= N_STAGE) ? SW'(N_STAGE - 1) : bus.lat_stage;
      lat_take    = (state == ST_RUN) && bus.lat_valid && !bus.flush_req &&
                    (bus.lat_cycles != '0);
      depth   = '0;
      any_req = 1'b0;
      for (int k = 0; k < N_STAGE; k++) begin
         if (bus.stallreq[k]) begin
            depth   = SW'(k);
            any_req = 1'b1;
         end
      end
      if (lat_take) begin
         if (lat_stage_c > depth) depth = lat_stage_c;
         any_req = 1'b1;
      end
      if (state == ST_HOLD) begin
         if (hold_stage > depth) depth = hold_stage;
         any_req = 1'b1;
      end
      if (state == ST_FLUSH) any_req = 1'b0;
   end

   pipe_ctrl_stall_mask #(.N_STAGE(N_STAGE), .SW(SW)) u_mask (
      .en    (any_req),
      .depth (depth),
      .mask  (stall_v)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         lat_cnt     <= '0;
         hold_stage  <= '0;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         new_pc_q    <= '0;
         stall_cnt_q <= '0;
         wd_cnt      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (lat_take && (bus.lat_cycles != LAT_W'(1))) begin
                  lat_cnt    <= bus.lat_cycles - LAT_W'(1);
                  hold_stage <= lat_stage_c;
                  busy_q     <= 1'b1;
                  state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // HOLD always has a nonzero count; the last stall cycle returns to RUN.
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt == LAT_W'(1)) begin
                  busy_q <= 1'b0;
                  state  <= ST_RUN;
               end
            end
            ST_FLUSH: state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase

         if (bus.flush_req) begin
            state    <= ST_FLUSH;
            lat_cnt  <= '0;
            busy_q   <= 1'b0;
            new_pc_q <= bus.flush_pc;
         end
         flush_q <= bus.flush_req;

         if (stall_v[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);

         if (!stall_v[0]) wd_cnt <= '0;
         else if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);

         if (flush_q) timeout_q <= 1'b0;
         else if ((TIMEOUT != 0) && stall_v[0] && (wd_cnt == WD_W'(TIMEOUT - 1)))
            timeout_q <= 1'b1;
      end
   end

   assign bus.stall     = stall_v;
   assign bus.flush     = flush_q;
   assign bus.new_pc    = new_pc_q;
   assign bus.busy      = busy_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.timeout   = timeout_q;
   assign bus.state     = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_pipe_ctrl;

   localparam int N_STAGE = 6;
   localparam int PC_W    = 32;
   localparam int LAT_W   = 6;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   chk_en = 1'b0;

   pipe_ctrl_if #(.N_STAGE(N_STAGE), .PC_W(PC_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

   pipe_ctrl #(
      .N_STAGE(N_STAGE), .PC_W(PC_W), .LAT_W(LAT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_left;     // stall cycles still owed by an accepted fixed-latency request
   int          m_hold;     // stage held by it
   bit          m_flush;    // flush pulse is visible this cycle
   logic [31:0] m_pc;
   int          m_cnt;
   int          m_wd;
   bit          m_timeout;

   function automatic int clamp_stage(input int s);
      return (s >= N_STAGE) ? N_STAGE - 1 : s;
   endfunction

   function automatic bit lat_accepted();
      return !m_flush && (m_left == 0) && bus.lat_valid && !bus.flush_req &&
             (bus.lat_cycles != 0);
   endfunction

   function automatic logic [N_STAGE-1:0] model_stall();
      int d;
      d = -1;
      if (m_flush) return '0;
      for (int k = 0; k < N_STAGE; k++) if (bus.stallreq[k]) d = k;
      if (m_left > 0) begin
         if (m_hold > d) d = m_hold;
      end else if (lat_accepted()) begin
         if (clamp_stage(int'(bus.lat_stage)) > d) d = clamp_stage(int'(bus.lat_stage));
      end
      return (d < 0) ? '0 : N_STAGE'((1 << (d + 1)) - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [N_STAGE-1:0] s;
      bit acc;
      if (rst) begin
         m_left = 0; m_hold = 0; m_flush = 0; m_pc = '0;
         m_cnt = 0; m_wd = 0; m_timeout = 0;
      end else begin
         s   = model_stall();
         acc = lat_accepted();
         if (s[0]) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_wd++;
            if (m_wd == TIMEOUT) m_timeout = 1;
         end else begin
            m_wd = 0;
         end
         if (m_flush) m_timeout = 0;
         if (bus.flush_req) begin
            m_flush = 1;
            m_pc    = bus.flush_pc;
            m_left  = 0;
         end else begin
            m_flush = 0;
            if (m_left > 0) m_left--;
            else if (acc) begin
               m_left = int'(bus.lat_cycles) - 1;
               m_hold = clamp_stage(int'(bus.lat_stage));
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      if (!rst && chk_en) begin
         check("stall", bus.stall, model_stall());
         check("flush", bus.flush, m_flush);
         if (m_flush) check("new_pc", bus.new_pc, m_pc);
         check("busy", bus.busy, m_left > 0);
         check("stall_cnt", bus.stall_cnt, m_cnt);
         check("timeout", bus.timeout, m_timeout);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [5:0] sr, input logic lv, input logic [2:0] ls,
                         input logic [5:0] lc, input logic fr, input logic [31:0] fp);
      bus.stallreq   = sr;
      bus.lat_valid  = lv;
      bus.lat_stage  = ls;
      bus.lat_cycles = lc;
      bus.flush_req  = fr;
      bus.flush_pc   = fp;
   endtask

   task automatic idle();
      set_in(6'b0, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", bus.stall, 6'b0);
      check("rst_flush", bus.flush, 1'b0);
      check("rst_new_pc", bus.new_pc, 32'h0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_cnt", bus.stall_cnt, 16'd0);
      check("rst_timeout", bus.timeout, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // single-cycle stage requests
      set_in(6'b000100, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      @(negedge clk); check("sr2_stall", bus.stall, 6'b000111);
      tick();
      set_in(6'b001100, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      @(negedge clk); check("sr3_stall", bus.stall, 6'b001111);
      check("sr_cnt1", bus.stall_cnt, 16'd1);
      tick();
      idle();
      @(negedge clk); check("sr_release", bus.stall, 6'b0);
      check("sr_cnt2", bus.stall_cnt, 16'd2);
      tick();

      // fixed-latency stall, stage 3, 5 cycles; second request in cycle 3 ignored
      set_in(6'b0, 1'b1, 3'd3, 6'd5, 1'b0, 32'h0);
      @(negedge clk); check("lat_c1_stall", bus.stall, 6'b001111);
      check("lat_c1_busy", bus.busy, 1'b0);
      tick();
      idle();
      @(negedge clk); check("lat_c2_busy", bus.busy, 1'b1);
      tick();
      set_in(6'b0, 1'b1, 3'd5, 6'd9, 1'b0, 32'h0);
      @(negedge clk); check("lat_c3_stall", bus.stall, 6'b001111);
      tick();
      idle();
      tick();
      @(negedge clk); check("lat_c5_stall", bus.stall, 6'b001111);
      check("lat_c5_busy", bus.busy, 1'b1);
      tick();
      @(negedge clk); check("lat_c6_stall", bus.stall, 6'b0);
      check("lat_c6_busy", bus.busy, 1'b0);
      check("lat_cnt7", bus.stall_cnt, 16'd7);
      tick();

      // out-of-range stage clamps; L=1 is one cycle; L=0 is ignored
      set_in(6'b0, 1'b1, 3'd7, 6'd1, 1'b0, 32'h0);
      @(negedge clk); check("clamp_stall", bus.stall, 6'b111111);
      tick();
      set_in(6'b0, 1'b1, 3'd2, 6'd0, 1'b0, 32'h0);
      @(negedge clk); check("l0_stall", bus.stall, 6'b0);
      check("l1_busy", bus.busy, 1'b0);
      check("clamp_cnt8", bus.stall_cnt, 16'd8);
      tick();
      idle();
      tick();

      // flush cancels HOLD; stall forced low during the pulse
      set_in(6'b0, 1'b1, 3'd2, 6'd6, 1'b0, 32'h0);
      tick();
      idle();
      tick();
      set_in(6'b0, 1'b0, 3'd0, 6'd0, 1'b1, 32'hBFC00380);
      @(negedge clk); check("fl_req_stall", bus.stall, 6'b000111);
      tick();
      set_in(6'b000010, 1'b1, 3'd4, 6'd3, 1'b0, 32'h0);
      @(negedge clk); check("fl_pulse", bus.flush, 1'b1);
      check("fl_pc", bus.new_pc, 32'hBFC00380);
      check("fl_stall", bus.stall, 6'b0);
      tick();
      idle();
      @(negedge clk); check("fl_after_flush", bus.flush, 1'b0);
      check("fl_after_busy", bus.busy, 1'b0);
      check("fl_after_stall", bus.stall, 6'b0);
      check("fl_cnt11", bus.stall_cnt, 16'd11);
      tick();

      // back-to-back flushes
      set_in(6'b0, 1'b0, 3'd0, 6'd0, 1'b1, 32'h80000100);
      tick();
      set_in(6'b0, 1'b0, 3'd0, 6'd0, 1'b1, 32'h80000200);
      @(negedge clk); check("ff_pc_a", bus.new_pc, 32'h80000100);
      tick();
      idle();
      @(negedge clk); check("ff_flush_b", bus.flush, 1'b1);
      check("ff_pc_b", bus.new_pc, 32'h80000200);
      tick();
      @(negedge clk); check("ff_done", bus.flush, 1'b0);
      tick();

      // watchdog: 8 consecutive PC-stall cycles
      set_in(6'b000010, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      for (int i = 0; i < 7; i++) tick();
      @(negedge clk); check("wd_c8_timeout", bus.timeout, 1'b0);
      tick();
      idle();
      @(negedge clk); check("wd_set", bus.timeout, 1'b1);
      check("wd_cnt19", bus.stall_cnt, 16'd19);
      tick();
      @(negedge clk); check("wd_sticky", bus.timeout, 1'b1);
      tick();
      set_in(6'b0, 1'b0, 3'd0, 6'd0, 1'b1, 32'h00001000);
      tick();
      idle();
      @(negedge clk); check("wd_flush_still", bus.timeout, 1'b1);
      tick();
      @(negedge clk); check("wd_cleared", bus.timeout, 1'b0);
      tick();

      // asynchronous reset in the middle of a 10-cycle hold
      set_in(6'b0, 1'b1, 3'd3, 6'd10, 1'b0, 32'h0);
      tick();
      idle();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_stall", bus.stall, 6'b0);
      check("arst_busy", bus.busy, 1'b0);
      check("arst_flush", bus.flush, 1'b0);
      check("arst_new_pc", bus.new_pc, 32'h0);
      check("arst_cnt", bus.stall_cnt, 16'd0);
      check("arst_timeout", bus.timeout, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); check("arst_post_stall", bus.stall, 6'b0);
      check("arst_post_busy", bus.busy, 1'b0);
      tick();
      @(negedge clk); check("arst_post2_stall", bus.stall, 6'b0);
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
